pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//  Receive-side counterpart of the PWM generator. Samples an asynchronous PWM input.
//  Measures period and high time in clk cycles, rising edge to rising edge.
//  Reports each completed cycle with a 1-cycle valid strobe and flags a stuck input.
//  Sits in loopback and monitor paths so duty-cycle logic can be checked in-system.
// PARAMETERS
//  CNT_WIDTH    32    width of period/high_time outputs and internal counters
//  TIMEOUT      1000  cycles without a detected edge before input is declared stuck; must be < 2**CNT_WIDTH-1
//  SYNC_STAGES  2     flops in pwm_in synchronizer (>=2)
// PORTS
//  clk         in   1          system clock, all logic on posedge
//  reset       in   1          synchronous, active-high
//  pwm_in      in   1          asynchronous PWM input
//  period      out  CNT_WIDTH  last measured period in cycles, registered
//  high_time   out  CNT_WIDTH  last measured high time in cycles, registered
//  meas_valid  out  1          1-cycle pulse when period/high_time update
//  locked      out  1          at least one valid measurement since last IDLE entry
//  stuck_high  out  1          timeout expired with input high
//  stuck_low   out  1          timeout expired with input low
// BEHAVIOUR
//  Reset (sync, high): all outputs 0, counters 0, synchronizer 0, state IDLE. Reset wins over every other event.
//  Synchronizer: pwm_in passes through SYNC_STAGES flops giving pwm_s; prev holds pwm_s delayed 1 cycle.
//  Edge detect:
//   - rise = pwm_s & ~prev
//   - fall = ~pwm_s & prev
//  cnt (cycles since last rise):
//   - rise -> cnt <= 1
//   - else -> cnt <= cnt+1, saturating at all-ones
//  hi_lat: on fall, hi_lat <= cnt (cycles pwm_s was high).
//  States:
//   IDLE    -> MEASURE on rise; no meas_valid, a full period is needed first.
//   MEASURE -> rise: period <= cnt, high_time <= hi_lat, meas_valid <= 1, locked <= 1.
//   MEASURE -> IDLE when cnt == TIMEOUT with no edge in that cycle; locked <= 0.
//  Timeout: when cnt == TIMEOUT with no edge (checked in both states):
//   - stuck_high <= pwm_s, stuck_low <= ~pwm_s
//   - period and high_time hold their last values
//  Stuck flags clear on the next detected edge (rise or fall).
//  Timeout runs in IDLE too; cnt counts from reset, so a constant input after reset is flagged.
//  meas_valid is 0 in every cycle that has no measurement.
//  Latency: pwm_in rise to meas_valid = SYNC_STAGES+1 clk cycles.
//  Widths and limits:
//   - Minimum measurable shape is high 1 cycle, low 1 cycle, giving period=2, high_time=1.
//   - Periods above TIMEOUT are not measured; the stuck flag covers them.
//  Mid-operation reset discards any partial measurement. First valid comes after two more rises.
// TESTING
//  1 Reset, then pwm_in period 100 / high 80 (generator defaults).
//    Required: first meas_valid at 2nd rise, period=100, high_time=80, locked=1; repeats every 100 cycles.
//  2 Switch to high 25 mid-stream.
//    Required: the period containing the change reports high_time=25, period=100.
//  3 pwm_in 1 cycle high, 2 low, repeated.
//    Required: period=3, high_time=1 on every rise after the first.
//  4 Hold pwm_in=1 for TIMEOUT+10 cycles.
//    Required: stuck_high=1, locked=0, period/high_time unchanged.
//    Then resume 100/80: stuck_high clears on the first fall; valid resumes one full period after the next rise.
//  5 Assert reset for 1 cycle 50 cycles into a period.
//    Required: next cycle all outputs 0, state IDLE; no meas_valid until the 2nd rise after reset.
//  6 pwm_in=0 from reset for TIMEOUT+1 cycles.
//    Required: stuck_low=1, meas_valid never asserts.

Source files
------------

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input, rising edge to rising edge.
// Emits a 1-cycle valid per completed cycle and flags an input stuck high or low.
module pwm_capture #(
  parameter int CNT_WIDTH   = 32,
  parameter int TIMEOUT     = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pwm_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 meas_valid,
  output logic                 locked,
  output logic                 stuck_high,
  output logic                 stuck_low
);
  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_WIDTH-1:0] TMO     = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   pwm_s, prev;
  logic                   rise, fall, timeout, do_meas;
  logic [CNT_WIDTH-1:0]   cnt, hi_lat;

  assign pwm_s   = sync[SYNC_STAGES-1];
  assign rise    = pwm_s & ~prev;
  assign fall    = ~pwm_s & prev;
  assign timeout = (cnt == TMO) && !rise && !fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync   <= '0;
      prev   <= 1'b0;
      cnt    <= '0;
      hi_lat <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      prev <= pwm_s;
      if (rise)                cnt <= CNT_WIDTH'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (fall) hi_lat <= cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A rise in IDLE only opens the window; a full period is needed before reporting.
  always_comb begin
    state_nxt = state;
    do_meas   = 1'b0;
    case (state)
      IDLE:    if (rise) state_nxt = MEASURE;
      MEASURE: begin
        if (rise)         do_meas   = 1'b1;
        else if (timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else begin
      meas_valid <= do_meas;
      if (do_meas) begin
        period    <= cnt;
        high_time <= hi_lat;
        locked    <= 1'b1;
      end
      if (state == MEASURE && timeout) locked <= 1'b0;
      // Timeout is checked in IDLE too, so a dead input straight out of reset is flagged.
      if (rise || fall) begin
        stuck_high <= 1'b0;
        stuck_low  <= 1'b0;
      end else if (timeout) begin
        stuck_high <= pwm_s;
        stuck_low  <= ~pwm_s;
      end
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed scenarios plus random PWM shapes,
// compared every cycle against a timestamp-based reference model.
module tb_pwm_capture;
  localparam int CW  = 16;
  localparam int TMO = 300;
  localparam int SS  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pwm_in = 1'b0;
  logic [CW-1:0] period, high_time;
  logic          meas_valid, locked, stuck_high, stuck_low;

  pwm_capture #(.CNT_WIDTH(CW), .TIMEOUT(TMO), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .period(period), .high_time(high_time), .meas_valid(meas_valid),
    .locked(locked), .stuck_high(stuck_high), .stuck_low(stuck_low)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the input as seen SS+1 edges late, with events located by edge
  // timestamps. Counts are differences between the current edge and the last rise.
  bit q[$];
  int e = 0, base = 0, hi_len = 0;
  bit armed = 0;
  int m_per = 0, m_hi = 0;
  bit m_mv = 0, m_lk = 0, m_sh = 0, m_sl = 0;
  int nvalid = 0;

  task automatic model(input bit v, input bit r);
    bit cur, prv, rs, fl;
    int c;
    e++;
    if (r) begin
      q.delete();
      for (int i = 0; i <= SS; i++) q.push_back(1'b0);
      base = e + 1; armed = 0; hi_len = 0;
      m_per = 0; m_hi = 0; m_mv = 0; m_lk = 0; m_sh = 0; m_sl = 0;
    end else begin
      cur = q[1]; prv = q[0];
      rs = cur && !prv;
      fl = !cur && prv;
      c  = e - base;
      m_mv = 0;
      if (rs) begin
        if (armed) begin
          m_mv = 1; m_per = c; m_hi = hi_len; m_lk = 1;
        end
        armed = 1;
      end else if (!fl && c == TMO) begin
        m_sh = cur; m_sl = !cur; m_lk = 0; armed = 0;
      end
      if (fl) hi_len = c;
      if (rs || fl) begin m_sh = 0; m_sl = 0; end
      if (rs) base = e;
      void'(q.pop_front());
      q.push_back(v);
    end
  endtask

  task automatic step(input bit v, input bit r);
    pwm_in = v;
    reset  = r;
    @(posedge clk);
    #1;
    model(v, r);
    if (meas_valid) nvalid++;
    chk("meas_valid", 32'(meas_valid), 32'(m_mv));
    chk("period",     32'(period),     32'(m_per));
    chk("high_time",  32'(high_time),  32'(m_hi));
    chk("locked",     32'(locked),     32'(m_lk));
    chk("stuck_high", 32'(stuck_high), 32'(m_sh));
    chk("stuck_low",  32'(stuck_low),  32'(m_sl));
  endtask

  task automatic wave(input int per, input int hi, input int n);
    for (int k = 0; k < n; k++)
      for (int j = 0; j < per; j++) step(j < hi, 1'b0);
  endtask

  task automatic hold(input bit v, input int n);
    for (int j = 0; j < n; j++) step(v, 1'b0);
  endtask

  initial begin
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("rst_period", 32'(period), 0);
    chk("rst_locked", 32'(locked), 0);

    // Dead-low input out of reset
    nvalid = 0;
    hold(1'b0, TMO + 5);
    chk("t6_stuck_low", 32'(stuck_low), 1);
    chk("t6_no_valid", 32'(nvalid), 0);

    // 100/80 stream, then duty change to 25
    wave(100, 80, 5);
    chk("t1_period", 32'(period), 100);
    chk("t1_high", 32'(high_time), 80);
    chk("t1_locked", 32'(locked), 1);
    chk("t1_stuck_low", 32'(stuck_low), 0);
    wave(100, 25, 3);
    chk("t2_period", 32'(period), 100);
    chk("t2_high", 32'(high_time), 25);

    // Narrow shape, then stuck high and recovery
    wave(3, 1, 10);
    chk("t3_period", 32'(period), 3);
    chk("t3_high", 32'(high_time), 1);
    hold(1'b1, TMO + 10);
    chk("t4_stuck_high", 32'(stuck_high), 1);
    chk("t4_locked", 32'(locked), 0);
    chk("t4_period", 32'(period), 3);
    chk("t4_high", 32'(high_time), 1);
    wave(100, 80, 3);
    chk("t4_resume_period", 32'(period), 100);
    chk("t4_resume_locked", 32'(locked), 1);

    // Reset 50 cycles into a period
    hold(1'b1, 50);
    step(1'b1, 1'b1);
    chk("t5_period", 32'(period), 0);
    chk("t5_high", 32'(high_time), 0);
    chk("t5_locked", 32'(locked), 0);
    wave(100, 80, 3);

    // Random shapes, holds and resets
    for (int it = 0; it < 40; it++) begin
      int sel, per, hi;
      sel = $urandom_range(0, 9);
      if (sel == 0) step(1'($urandom_range(0, 1)), 1'b1);
      else if (sel == 1) hold(1'($urandom_range(0, 1)), TMO + $urandom_range(0, 20));
      else begin
        per = $urandom_range(2, 150);
        hi  = $urandom_range(1, per - 1);
        wave(per, hi, $urandom_range(1, 4));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule
